// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule. PC-1 is applied on key load, then one PC-2 subkey
// is emitted per cycle on a valid/ready stream, in forward (encrypt) or reverse (decrypt) order.
module des_key_sched_seq #(
    parameter int          ROUNDS      = 16,
    parameter logic [15:0] SHIFT1_MASK = 16'h8103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk_out,
    output logic [4:0]  sk_round,
    output logic        sk_last,
    output logic        busy
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both
    // high. A producer holds valid and its payload stable until that transfer.
    // All vectors are [N-1:0]. DES bit n (where 1 = MSB) is at index N-n.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] LP_ROUNDS = 5'(ROUNDS);

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // A left rotation moves each bit toward the MSB, and the MSB wraps around to the LSB.
    function automatic logic [27:0] rot_half(input logic [27:0] h, input logic left,
                                             input logic one);
        logic [27:0] r;
        case ({left, one})
            2'b11:   r = {h[26:0], h[27]};
            2'b10:   r = {h[25:0], h[27:26]};
            2'b01:   r = {h[0], h[27:1]};
            default: r = {h[1:0], h[27:2]};
        endcase
        return r;
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left,
                                           input logic one);
        return {rot_half(cd[55:28], left, one), rot_half(cd[27:0], left, one)};
    endfunction

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [55:0] r_cd;
    logic        r_mode;

    state_t      w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [55:0] w_cd_nxt;
    logic        w_mode_nxt;

    logic [55:0] w_pc1;
    logic [47:0] w_pc2;
    logic [3:0]  w_dec_idx;
    logic        w_enc_one;
    logic        w_dec_one;
    logic        w_unused_parity;

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign w_pc1[55-g] = key_in[64-PC1_TAB[g]];
    end

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign w_pc2[47-g] = r_cd[56-PC2_TAB[g]];
    end

    // The parity bits (DES bits 8, 16, ..., 64) never reach the schedule.
    assign w_unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8], key_in[0]};

    // The next encrypt round is cnt+1, so its mask bit is at index cnt.
    // Decrypt undoes round ROUNDS+1-cnt, so its mask bit is at index ROUNDS-cnt.
    assign w_enc_one = SHIFT1_MASK[r_cnt[3:0]];
    assign w_dec_idx = LP_ROUNDS[3:0] - r_cnt[3:0];
    assign w_dec_one = SHIFT1_MASK[w_dec_idx];

    assign key_ready = (r_state == ST_IDLE) && !rst;
    assign sk_valid  = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN);
    assign sk_out    = w_pc2;
    assign sk_round  = r_mode ? (LP_ROUNDS + 5'd1 - r_cnt) : r_cnt;
    assign sk_last   = (r_cnt == LP_ROUNDS);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cd_nxt    = r_cd;
        w_mode_nxt  = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (key_valid && key_ready) begin
                    w_mode_nxt  = decrypt;
                    w_cnt_nxt   = 5'd1;
                    w_state_nxt = ST_RUN;
                    // A full decrypt walk starts at C16D16, which equals C0D0.
                    w_cd_nxt    = decrypt ? w_pc1 : rot_cd(w_pc1, 1'b1, SHIFT1_MASK[0]);
                end
            end
            ST_RUN: begin
                if (sk_ready) begin
                    if (r_cnt == LP_ROUNDS) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                        w_cd_nxt  = r_mode ? rot_cd(r_cd, 1'b0, w_dec_one)
                                           : rot_cd(r_cd, 1'b1, w_enc_one);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_cd    <= 56'd0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cd    <= w_cd_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
Sequential DES key-schedule engine. Accepts one 64-bit key, applies PC-1, then emits the round subkeys as a valid/ready stream, one per cycle. Each subkey is PC-2 of the current C/D halves. Successor to the combinational single-round rotator: it adds round sequencing, per-round rotation selection from a parametrised mask, and a decrypt mode that walks the schedule in reverse using right rotations. Sits between the key-load interface and the round datapath.

Parameters:
ROUNDS, 16, number of subkeys emitted per key (1..16).
SHIFT1_MASK, 16'h8103, bit r-1 set means round r rotates by 1; clear means rotate by 2. Default selects rounds 1, 2, 9, 16.

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
key_valid  input  1  key offer
key_ready  output  1  engine can accept a key
key_in  input  [64:1]  DES key, [1]=MSB; parity bits 8,16,..,64 ignored
decrypt  input  1  mode, sampled only on key handshake; 1 = reverse order
sk_valid  output  1  subkey available
sk_ready  input  1  consumer accepts subkey
sk_out  output  [48:1]  subkey, [1]=MSB
sk_round  output  [5:1]  DES subkey index of sk_out (1..ROUNDS)
sk_last  output  1  sk_out is the final subkey for this key
busy  output  1  engine in RUN state

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). While rst=1: state<=IDLE, cnt<=0, CD<=0, mode<=0. key_ready=0, sk_valid=0, sk_last=0, busy=0, sk_round=0, sk_out=PC2(0)=0.
- Halves: C=CD[1:28], D=CD[29:56]. Each half is rotated independently. rotl1/rotl2 move bit 1 toward bit 28. rotr1/rotr2 are the exact inverses.
- s(r) = SHIFT1_MASK[r-1] ? 1 : 2.
- States: IDLE and RUN. key_ready = (state==IDLE) && !rst. busy = (state==RUN). sk_valid = (state==RUN).
- IDLE, when key_valid && key_ready:
  - mode<=decrypt; cnt<=1; state<=RUN.
  - encrypt: CD<=rotl_s(1)(PC1(key_in)).
  - decrypt: CD<=PC1(key_in), since the full schedule returns to C0D0.
- Latency: key accepted at edge T; first subkey is valid in the cycle after T.
- sk_out = PC2(CD), combinational from the CD register.
- sk_round = mode ? ROUNDS+1-cnt : cnt.
- sk_last = (cnt==ROUNDS).
- RUN, when sk_valid && sk_ready:
  - If cnt==ROUNDS: state<=IDLE. sk_valid drops in the next cycle.
  - Otherwise cnt<=cnt+1, and:
    - encrypt: CD<=rotl_s(cnt+1)(CD).
    - decrypt: CD<=rotr_s(ROUNDS+1-cnt)(CD).
- Throughput: with sk_ready held high, one subkey per cycle, ROUNDS consecutive cycles.
- Backpressure: while sk_valid && !sk_ready, CD, cnt, sk_out, sk_round and sk_last hold stable.
- key_valid during RUN is ignored; key_ready=0 there. The next key is accepted no earlier than the first IDLE cycle after the last subkey handshake, so there are ROUNDS+1 cycles minimum per key.
- rst during RUN aborts the schedule: sk_valid=0 in the next cycle and no residual subkeys are emitted.
- Decrypt mode is correct only when the sum of s(r) over r=1..ROUNDS ≡ 0 mod 28. This holds for the default; other configurations are encrypt-only.
- PC-1 and PC-2 are the FIPS 46-3 tables using [1]=MSB numbering.
- cnt is 5 bits and never exceeds ROUNDS.

Test Plan:
- Encrypt, key 133457799BBCDFF1, sk_ready=1:
  - first subkey the cycle after the handshake: sk_round=1, sk_out=1B02EFFC7072.
  - next cycle: sk_round=2, sk_out=79AED9DBC9E5.
  - 16th cycle: sk_round=16, sk_last=1, sk_out=CB3D8B0E17F5.
  - busy falls the following cycle.
- Decrypt, same key: first subkey has sk_round=16, sk_out=CB3D8B0E17F5. Last has sk_round=1, sk_out=1B02EFFC7072, sk_last=1. All 16 subkeys match the encrypt sequence reversed.
- Backpressure: randomly toggle sk_ready during an encrypt run. sk_out and sk_round must hold while stalled, exactly 16 handshakes must occur, and the values must be unchanged from the first scenario.
- Key during RUN: drive key_valid with key 0000000000000000 mid-run. key_ready stays 0, the stream is unaffected, and the new key is accepted only after return to IDLE.
- Reset mid-run: assert rst after the 5th handshake. The cycle after, sk_valid=0, busy=0, sk_out=0. After rst deasserts, a fresh key restarts at sk_round=1 with correct values.
- Parity independence: key 133457799BBCDFF1 with all parity bits flipped (XOR 0101010101010101) must produce an identical 16-subkey sequence.
